dmem_arbiter: RTL and testbench

//  Shares the single data-memory port (dmem32x64k) between the core pipeline (ID/EX load/store) and
//  an external loader/debug requester (program/data preload, memory dump). Per-cycle 2-way arbitration

---
 rtl/dmem_arbiter_pkg.sv | 30 +++
 rtl/dmem_arbiter_chk.sv | 13 +
 rtl/dmem_arbiter_rr_pick2.sv | 29 ++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester IDs and
// default geometry of the dmem32x64k port.
package dmem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W    = 16;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_MAX_BURST = 16;

    typedef enum logic {
        ARB    = 1'b0,
        LBURST = 1'b1
    } arb_state_e;

    typedef enum logic {
        CORE   = 1'b0,
        LOADER = 1'b1
    } req_id_e;

    // Map a one-hot grant vector {loader, core} to the winning requester.
    function automatic req_id_e winner_of(input logic [1:0] gnt);
        req_id_e id;
        if (gnt[1]) begin
            id = LOADER;
        end else begin
            id = CORE;
        end
        return id;
    endfunction

endpackage

// File: rtl/dmem_arbiter_chk.sv
// Protocol checker for the data-memory arbiter outputs; simulation use only.
module dmem_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic c_gnt,
    input logic l_gnt,
    input logic m_w
);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(c_gnt && l_gnt));
    a_write_needs_gnt: assert property (@(posedge clk) disable iff (rst) (m_w |-> (c_gnt || l_gnt)));

endmodule

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-input alternating-priority picker. Bit 0 is the core, bit 1 the loader;
// force0 hands contention to bit 0 regardless of history.
module dmem_arbiter_rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       force0,
    output logic [1:0] gnt
);

    // One-hot pick: single requester wins outright, contention goes to the one not served last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (force0 || (last == LOADER)) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the core pipeline and the loader/debug
// requester, with alternating priority, locked loader bursts and rvalid return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_w,
    output logic [DATA_W-1:0] m_d,
    input  logic [DATA_W-1:0] m_q
);

    localparam int unsigned     CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_e       state_r, state_nxt_s;
    req_id_e          last_gnt_r, last_gnt_nxt_s;
    logic [CNT_W-1:0] beat_cnt_r, beat_cnt_nxt_s;
    logic             core_prio_r, core_prio_nxt_s;
    logic             set_prio_s;
    logic [1:0]       pick_gnt_s;
    logic             c_gnt_s, l_gnt_s;
    logic             c_rvalid_r, l_rvalid_r;

    dmem_arbiter_rr_pick2 u_pick (
        .req    ({l_req, c_req}),
        .last   (last_gnt_r),
        .force0 (core_prio_r),
        .gnt    (pick_gnt_s)
    );

    // Grant selection, burst tracking and next-state computation.
    always_comb begin
        state_nxt_s    = state_r;
        beat_cnt_nxt_s = beat_cnt_r;
        set_prio_s     = 1'b0;
        c_gnt_s        = 1'b0;
        l_gnt_s        = 1'b0;
        case (state_r)
            ARB: begin
                c_gnt_s = pick_gnt_s[0];
                l_gnt_s = pick_gnt_s[1];
                if (pick_gnt_s[1] && l_lock) begin
                    beat_cnt_nxt_s = CNT_ONE;
                    if (CNT_ONE >= CNT_MAX) begin
                        // A single-beat limit releases immediately and owes the core a turn.
                        set_prio_s  = 1'b1;
                        state_nxt_s = ARB;
                    end else begin
                        state_nxt_s = LBURST;
                    end
                end else begin
                    state_nxt_s = ARB;
                end
            end
            LBURST: begin
                if (l_req && l_lock) begin
                    l_gnt_s = 1'b1;
                    if (beat_cnt_r >= (CNT_MAX - CNT_ONE)) begin
                        beat_cnt_nxt_s = CNT_MAX;
                        set_prio_s     = 1'b1;
                        state_nxt_s    = ARB;
                    end else begin
                        beat_cnt_nxt_s = beat_cnt_r + CNT_ONE;
                        state_nxt_s    = LBURST;
                    end
                end else begin
                    // Burst released: this cycle is arbitrated normally, no relock possible.
                    c_gnt_s     = pick_gnt_s[0];
                    l_gnt_s     = pick_gnt_s[1];
                    state_nxt_s = ARB;
                end
            end
            default: begin
                state_nxt_s = ARB;
            end
        endcase
    end

    // Core-priority flag and last-winner bookkeeping.
    always_comb begin
        core_prio_nxt_s = core_prio_r;
        last_gnt_nxt_s  = last_gnt_r;
        if (c_gnt_s || !c_req) begin
            core_prio_nxt_s = 1'b0;
        end else if (set_prio_s) begin
            core_prio_nxt_s = 1'b1;
        end else begin
            core_prio_nxt_s = core_prio_r;
        end
        if (c_gnt_s || l_gnt_s) begin
            last_gnt_nxt_s = winner_of({l_gnt_s, c_gnt_s});
        end else begin
            last_gnt_nxt_s = last_gnt_r;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ARB;
            last_gnt_r  <= LOADER;
            beat_cnt_r  <= '0;
            core_prio_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            last_gnt_r  <= last_gnt_nxt_s;
            beat_cnt_r  <= beat_cnt_nxt_s;
            core_prio_r <= core_prio_nxt_s;
        end
    end

    // Read-return strobes, aligned with the registered dmem output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rvalid_r <= 1'b0;
            l_rvalid_r <= 1'b0;
        end else begin
            c_rvalid_r <= c_gnt_s & ~c_we;
            l_rvalid_r <= l_gnt_s & ~l_we;
        end
    end

    assign c_gnt    = c_gnt_s;
    assign l_gnt    = l_gnt_s;
    assign c_rvalid = c_rvalid_r;
    assign l_rvalid = l_rvalid_r;
    assign c_rdata  = m_q;
    assign l_rdata  = m_q;
    assign m_addr   = l_gnt_s ? l_addr : c_addr;
    assign m_d      = l_gnt_s ? l_wdata : c_wdata;
    assign m_w      = (c_gnt_s & c_we) | (l_gnt_s & l_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with a registered 64k x 32 memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [15:0] c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
    logic [15:0] l_addr;
    logic [31:0] l_wdata, l_rdata;
    logic [15:0] m_addr;
    logic        m_w;
    logic [31:0] m_d, m_q;

    logic [31:0] mem [0:65535];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Registered memory: write at the edge, read data one cycle after the address.
    always @(posedge clk) begin
        if (m_w) mem[m_addr] <= m_d;
        m_q <= mem[m_addr];
    end

    dmem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .m_addr(m_addr), .m_w(m_w), .m_d(m_d), .m_q(m_q)
    );

    dmem_arbiter_chk u_chk (.clk(clk), .rst(rst), .c_gnt(c_gnt), .l_gnt(l_gnt), .m_w(m_w));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic got_c, got_l, hold_c, hold_l;
        logic pend_c, pend_l;
        logic [31:0] exp_cd, exp_ld;
        int k;

        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[16'h0010] = 32'hDEADBEEF;
        mem[16'h0100] = 32'hAAAA5555;
        rst = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = 16'h0; c_wdata = 32'h0;
        l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = 16'h0; l_wdata = 32'h0;

        // Reset state
        @(negedge clk);
        chk("rst_c_rvalid", c_rvalid, 1'b0);
        chk("rst_l_rvalid", l_rvalid, 1'b0);
        chk("rst_c_gnt", c_gnt, 1'b0);
        chk("rst_l_gnt", l_gnt, 1'b0);
        chk("rst_m_w", m_w, 1'b0);
        tick();
        rst = 1'b0;

        // 1: lone core read of 0x0010
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        @(negedge clk);
        chk("t1_c_gnt", c_gnt, 1'b1);
        chk("t1_l_gnt", l_gnt, 1'b0);
        chk("t1_m_addr", m_addr, 16'h0010);
        chk("t1_m_w", m_w, 1'b0);
        tick();
        c_req = 1'b0;
        @(negedge clk);
        chk("t1_c_rvalid", c_rvalid, 1'b1);
        chk("t1_c_rdata", c_rdata, 32'hDEADBEEF);
        chk("t1_l_rvalid", l_rvalid, 1'b0);
        tick();

        // 2: continuous contention alternates, core first after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        l_req = 1'b1; l_we = 1'b0; l_lock = 1'b0; l_addr = 16'h0100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_c_gnt", c_gnt, (i % 2) == 0);
            chk("t2_l_gnt", l_gnt, (i % 2) == 1);
            if (i > 0) begin
                chk("t2_c_rvalid", c_rvalid, (i % 2) == 1);
                chk("t2_l_rvalid", l_rvalid, (i % 2) == 0);
                if ((i % 2) == 1) chk("t2_c_rdata", c_rdata, 32'hDEADBEEF);
                else              chk("t2_l_rdata", l_rdata, 32'hAAAA5555);
            end
            tick();
        end
        c_req = 1'b0; l_req = 1'b0;
        @(negedge clk);
        chk("t2_last_l_rvalid", l_rvalid, 1'b1);
        chk("t2_last_l_rdata", l_rdata, 32'hAAAA5555);
        tick();

        // 3: locked burst of 20 writes with the core waiting
        k = 0;
        l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1; l_addr = 16'h0200; l_wdata = 32'd0;
        c_req = 1'b0; c_we = 1'b0; c_addr = 16'h0300;
        for (int cyc = 0; cyc < 21; cyc++) begin
            @(negedge clk);
            chk("t3_l_gnt", l_gnt, cyc != 16);
            chk("t3_c_gnt", c_gnt, cyc == 16);
            got_c = c_gnt;
            got_l = l_gnt;
            tick();
            if (cyc == 0) c_req = 1'b1;
            if (got_c) c_req = 1'b0;
            if (got_l) begin
                k++;
                l_addr  = 16'h0200 + 16'(k);
                l_wdata = 32'(k);
                if (k == 20) l_req = 1'b0;
            end
        end
        l_req = 1'b0; l_lock = 1'b0; c_req = 1'b0;
        @(negedge clk);
        chk("t3_beats", k, 20);
        chk("t3_mem_0f", mem[16'h020F], 32'd15);
        chk("t3_mem_13", mem[16'h0213], 32'd19);
        tick();

        // 4: same-cycle loader write and core read of 0x0100
        l_req = 1'b1; l_we = 1'b1; l_lock = 1'b0; l_addr = 16'h0100; l_wdata = 32'h00001234;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0100;
        @(negedge clk);
        chk("t4_c_gnt", c_gnt, 1'b1);
        chk("t4_l_gnt", l_gnt, 1'b0);
        chk("t4_m_w_a", m_w, 1'b0);
        tick();
        c_req = 1'b0;
        @(negedge clk);
        chk("t4_l_gnt_b", l_gnt, 1'b1);
        chk("t4_m_w_b", m_w, 1'b1);
        chk("t4_c_rvalid_old", c_rvalid, 1'b1);
        chk("t4_c_rdata_old", c_rdata, 32'hAAAA5555);
        tick();
        l_req = 1'b0; c_req = 1'b1;
        @(negedge clk);
        chk("t4_c_gnt_c", c_gnt, 1'b1);
        tick();
        c_req = 1'b0;
        @(negedge clk);
        chk("t4_c_rvalid_new", c_rvalid, 1'b1);
        chk("t4_c_rdata_new", c_rdata, 32'h00001234);
        tick();

        // 5: async reset mid-burst with a loader read outstanding
        l_req = 1'b1; l_we = 1'b0; l_lock = 1'b1; l_addr = 16'h0010;
        @(negedge clk);
        chk("t5_l_gnt0", l_gnt, 1'b1);
        tick();
        @(negedge clk);
        chk("t5_l_gnt1", l_gnt, 1'b1);
        tick();
        chk("t5_l_rvalid_pre", l_rvalid, 1'b1);
        rst = 1'b1; l_req = 1'b0;
        #1;
        chk("t5_l_rvalid_rst", l_rvalid, 1'b0);
        chk("t5_m_w_rst", m_w, 1'b0);
        chk("t5_l_gnt_rst", l_gnt, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        l_req = 1'b1;
        #1;
        chk("t5_arb_c_gnt", c_gnt, 1'b1);
        chk("t5_arb_l_gnt", l_gnt, 1'b0);
        tick();
        c_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
        tick();

        // 6: random mix checked against invariants and a memory shadow
        pend_c = 1'b0; pend_l = 1'b0; exp_cd = 32'h0; exp_ld = 32'h0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            chk("t6_onehot", c_gnt & l_gnt, 1'b0);
            chk("t6_m_w", m_w, (c_gnt & c_we) | (l_gnt & l_we));
            if (n > 0) begin
                chk("t6_c_rvalid", c_rvalid, pend_c);
                chk("t6_l_rvalid", l_rvalid, pend_l);
                if (pend_c) chk("t6_c_rdata", c_rdata, exp_cd);
                if (pend_l) chk("t6_l_rdata", l_rdata, exp_ld);
            end
            pend_c = c_gnt & ~c_we;
            pend_l = l_gnt & ~l_we;
            if (pend_c) exp_cd = mem[c_addr];
            if (pend_l) exp_ld = mem[l_addr];
            hold_c = c_req & ~c_gnt;
            hold_l = l_req & ~l_gnt;
            tick();
            if (!hold_c) begin
                c_req   = ($urandom_range(0, 3) != 0);
                c_we    = $urandom_range(0, 1) != 0;
                c_addr  = 16'($urandom_range(0, 7));
                c_wdata = $urandom;
            end
            if (!hold_l) begin
                l_req   = ($urandom_range(0, 3) != 0);
                l_we    = $urandom_range(0, 1) != 0;
                l_lock  = ($urandom_range(0, 3) != 0);
                l_addr  = 16'($urandom_range(0, 7));
                l_wdata = $urandom;
            end
        end
        c_req = 1'b0; l_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
